// File: rtl/pipeline_pkg.sv
// Shared constants and types for the foreground fetch path of the compositing pipeline.
package pipeline_pkg;

  localparam int R_WIDTH           = 5;
  localparam int G_WIDTH           = 6;
  localparam int B_WIDTH           = 5;
  localparam int PIXEL_SIZE        = R_WIDTH + G_WIDTH + B_WIDTH;
  localparam int PRECISION         = 11;
  localparam int FG_WIDTH          = 800;
  localparam int FG_HEIGHT         = 600;
  localparam int FETCH_DELAY       = 6;
  localparam int SRAM_READ_LATENCY = 3;
  localparam int ADDR_WIDTH        = 20;

  localparam logic [ADDR_WIDTH-1:0] BANK_OFFSET = ADDR_WIDTH'(FG_WIDTH * FG_HEIGHT);

  typedef struct packed {
    logic valid;
    logic skip;
  } resp_tag_t;

  // Constant multiply by the row pitch, unrolled into shift-add terms.
  function automatic logic [ADDR_WIDTH-1:0] mul_fg_width(input logic [ADDR_WIDTH-1:0] v);
    logic [ADDR_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++) begin
      if (FG_WIDTH[i]) acc = acc + (v << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/pipeline_delay_line.sv
// Reset-clearable shift register with one intermediate tap.
module pipeline_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned TAP   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_tap
);

  if (DEPTH == 0) begin : g_bypass
    assign o_data = i_data;
    assign o_tap  = i_data;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        for (int k = 0; k < int'(DEPTH); k++) r_stage[k] <= '0;
      end else begin
        r_stage[0] <= i_data;
        for (int k = 1; k < int'(DEPTH); k++) r_stage[k] <= r_stage[k-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
    assign o_tap  = r_stage[TAP];
  end

endmodule

// File: rtl/pipeline_foreground_fetch_responder.sv
// Answers foreground pixel requests from a double-buffered SRAM frame store with a fixed
// request-to-response latency and full throughput.
module pipeline_foreground_fetch_responder
  import pipeline_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic signed [PRECISION:0] req_x,
  input  logic signed [PRECISION:0] req_y,
  input  logic                   req_active,
  input  logic                   frame_start,
  input  logic                   ctrl_fb_select,
  output logic [PIXEL_SIZE-1:0]  resp_pixel,
  output logic                   resp_skip,
  output logic                   resp_ready,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic                   sram_re,
  input  logic [PIXEL_SIZE-1:0]  sram_rdata,
  input  logic                   sram_rvalid,
  output logic                   active_bank,
  output logic                   err_latency
);

  if (FETCH_DELAY < SRAM_READ_LATENCY + 2) begin : g_bad_delay
    $error("FETCH_DELAY must be at least SRAM_READ_LATENCY+2");
  end
  if (2 * FG_WIDTH * FG_HEIGHT > (1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("ADDR_WIDTH cannot hold both frame banks");
  end

  localparam int PAD_DEPTH = FETCH_DELAY - SRAM_READ_LATENCY - 2;

  logic                  r_bank;
  logic                  r_sram_re;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic                  r_err;
  logic                  r_cap_miss;
  logic [PIXEL_SIZE-1:0] r_cap_pixel;

  logic                  w_bank;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_x;
  logic [ADDR_WIDTH-1:0] w_y;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_expect;
  resp_tag_t             w_tag_in;
  resp_tag_t             w_tag_cap;
  resp_tag_t             w_tag_out;
  logic [PIXEL_SIZE:0]   w_pad_out;

  // A request coinciding with frame_start already uses the newly selected bank.
  assign w_bank     = frame_start ? ctrl_fb_select : r_bank;
  assign w_in_range = req_active && (req_x >= 0) && (req_x < FG_WIDTH) &&
                      (req_y >= 0) && (req_y < FG_HEIGHT);
  assign w_x        = ADDR_WIDTH'(req_x[PRECISION-1:0]);
  assign w_y        = ADDR_WIDTH'(req_y[PRECISION-1:0]);
  assign w_addr     = (w_bank ? BANK_OFFSET : '0) + mul_fg_width(w_y) + w_x;

  assign w_tag_in.valid = req_valid;
  assign w_tag_in.skip  = ~w_in_range;

  // Slot whose read data is due on sram_rdata this cycle.
  assign w_expect = w_tag_cap.valid & ~w_tag_cap.skip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bank      <= 1'b0;
      r_sram_re   <= 1'b0;
      r_sram_addr <= '0;
      r_err       <= 1'b0;
      r_cap_miss  <= 1'b0;
      r_cap_pixel <= '0;
    end else begin
      r_bank    <= w_bank;
      r_sram_re <= req_valid & w_in_range;
      if (req_valid && w_in_range) r_sram_addr <= w_addr;
      r_cap_miss  <= w_expect & ~sram_rvalid;
      r_cap_pixel <= (w_expect && sram_rvalid) ? sram_rdata : '0;
      r_err       <= r_err | (w_expect & ~sram_rvalid);
    end
  end

  pipeline_delay_line #(
    .WIDTH ($bits(resp_tag_t)),
    .DEPTH (FETCH_DELAY),
    .TAP   (SRAM_READ_LATENCY)
  ) u_tag_line (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (w_tag_in),
    .o_data  (w_tag_out),
    .o_tap   (w_tag_cap)
  );

  pipeline_delay_line #(
    .WIDTH (PIXEL_SIZE + 1),
    .DEPTH (PAD_DEPTH),
    .TAP   (0)
  ) u_pad_line (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  ({r_cap_miss, r_cap_pixel}),
    .o_data  (w_pad_out),
    .o_tap   ()
  );

  assign resp_ready  = w_tag_out.valid;
  assign resp_skip   = w_tag_out.valid & (w_tag_out.skip | w_pad_out[PIXEL_SIZE]);
  assign resp_pixel  = w_pad_out[PIXEL_SIZE-1:0];
  assign sram_re     = r_sram_re;
  assign sram_addr   = r_sram_addr;
  assign active_bank = r_bank;
  assign err_latency = r_err;

endmodule
